// File: rtl/ddr_tx_pkg.sv
// Shared types and constants for the DDR write-data transmit path.
package ddr_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_POST = 2'd3
  } tx_state_t;

  // DQS patterns are packed as {LO, HI}
  localparam logic [1:0] DQS_TOGGLE = 2'b01;
  localparam logic [1:0] DQS_IDLE   = 2'b00;

  function automatic int cnt_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/ddr_wdata_tx_if.sv
// Write-beat handshake plus ODDR-side pad bundle for ddr_wdata_tx.
interface ddr_wdata_tx_if #(
  parameter int DQ_W = 16
);
  localparam int DM_W = DQ_W / 8;

  logic                WR_VALID;
  logic                WR_READY;
  logic [2*DQ_W-1:0]   WR_DATA;
  logic [2*DM_W-1:0]   WR_MASK;
  logic [DQ_W-1:0]     DQ_HI;
  logic [DQ_W-1:0]     DQ_LO;
  logic [DM_W-1:0]     DM_HI;
  logic [DM_W-1:0]     DM_LO;
  logic                DQS_HI;
  logic                DQS_LO;
  logic                DQ_OE;
  logic                DQS_OE;
  logic                BUSY;
  logic [7:0]          UNDERRUN_CNT;

  modport master (
    output WR_VALID, WR_DATA, WR_MASK,
    input  WR_READY, DQ_HI, DQ_LO, DM_HI, DM_LO, DQS_HI, DQS_LO,
           DQ_OE, DQS_OE, BUSY, UNDERRUN_CNT
  );

  modport slave (
    input  WR_VALID, WR_DATA, WR_MASK,
    output WR_READY, DQ_HI, DQ_LO, DM_HI, DM_LO, DQS_HI, DQS_LO,
           DQ_OE, DQS_OE, BUSY, UNDERRUN_CNT
  );
endinterface

// File: rtl/ddr_tx_oreg.sv
// Registered pad-side bank: DQ/DM load on demand, DQS and enables every cycle.
module ddr_tx_oreg #(
  parameter int DQ_W = 16,
  parameter int DM_W = 2
) (
  input  logic              clk_int,
  input  logic              clr,
  input  logic              ld_data,
  input  logic [2*DQ_W-1:0] data,
  input  logic [2*DM_W-1:0] mask,
  input  logic [1:0]        dqs_pat,
  input  logic              dq_oe_d,
  input  logic              dqs_oe_d,
  output logic [DQ_W-1:0]   dq_hi,
  output logic [DQ_W-1:0]   dq_lo,
  output logic [DM_W-1:0]   dm_hi,
  output logic [DM_W-1:0]   dm_lo,
  output logic              dqs_hi,
  output logic              dqs_lo,
  output logic              dq_oe,
  output logic              dqs_oe
);

  // initialisers give a defined pad state at time zero in simulation
  logic [DQ_W-1:0] dq_hi_q  = '0;
  logic [DQ_W-1:0] dq_lo_q  = '0;
  logic [DM_W-1:0] dm_hi_q  = '0;
  logic [DM_W-1:0] dm_lo_q  = '0;
  logic [1:0]      dqs_q    = '0;
  logic            dq_oe_q  = 1'b0;
  logic            dqs_oe_q = 1'b0;

  always_ff @(posedge clk_int) begin
    if (clr) begin
      dq_hi_q  <= '0;
      dq_lo_q  <= '0;
      dm_hi_q  <= '0;
      dm_lo_q  <= '0;
      dqs_q    <= '0;
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
    end else begin
      if (ld_data) begin
        dq_hi_q <= data[DQ_W-1:0];
        dq_lo_q <= data[2*DQ_W-1:DQ_W];
        dm_hi_q <= mask[DM_W-1:0];
        dm_lo_q <= mask[2*DM_W-1:DM_W];
      end
      dqs_q    <= dqs_pat;
      dq_oe_q  <= dq_oe_d;
      dqs_oe_q <= dqs_oe_d;
    end
  end

  assign dq_hi  = dq_hi_q;
  assign dq_lo  = dq_lo_q;
  assign dm_hi  = dm_hi_q;
  assign dm_lo  = dm_lo_q;
  assign dqs_hi = dqs_q[0];
  assign dqs_lo = dqs_q[1];
  assign dq_oe  = dq_oe_q;
  assign dqs_oe = dqs_oe_q;

endmodule

// File: rtl/ddr_wdata_tx.sv
// DDR write-data transmitter: bursts of BEATS beats with DQS preamble/postamble.
//   state | meaning
//   IDLE  | pads off, waiting for WR_VALID
//   PRE   | preamble on pads; first beat (or underrun) taken here
//   DATA  | streaming beats until BEATS accepted
//   POST  | burst done; continue seamlessly or drive postamble
module ddr_wdata_tx
  import ddr_tx_pkg::*;
#(
  parameter int DQ_W  = 16,
  parameter int BEATS = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  ddr_wdata_tx_if.slave bus
);

  localparam int DM_W  = DQ_W / 8;
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  tx_state_t         state    = ST_IDLE;
  tx_state_t         state_nxt;
  logic [CNT_W-1:0]  beat_cnt = '0;
  logic [CNT_W-1:0]  beat_cnt_nxt;
  logic [CNT_W-1:0]  beat_inc;
  logic [7:0]        urun_cnt = '0;
  logic              beat_ok;
  logic              urun;

  logic              ld_data;
  logic [1:0]        dqs_pat;
  logic              dq_oe_d;
  logic              dqs_oe_d;
  logic [2*DQ_W-1:0] tx_data;
  logic [2*DM_W-1:0] tx_mask;

  assign beat_ok  = bus.WR_VALID && (state != ST_IDLE);
  assign urun     = !bus.WR_VALID && ((state == ST_PRE) || (state == ST_DATA));
  assign beat_inc = beat_cnt + ONE_C;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      urun_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (urun && (urun_cnt != 8'hFF))
        urun_cnt <= urun_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      ST_IDLE: if (bus.WR_VALID) state_nxt = ST_PRE;
      ST_PRE: begin
        beat_cnt_nxt = beat_ok ? ONE_C : '0;
        state_nxt    = (beat_ok && (BEATS_C == ONE_C)) ? ST_POST : ST_DATA;
      end
      ST_DATA: if (beat_ok) begin
        beat_cnt_nxt = beat_inc;
        if (beat_inc == BEATS_C) state_nxt = ST_POST;
      end
      ST_POST: begin
        if (beat_ok) begin
          beat_cnt_nxt = ONE_C;
          state_nxt    = (BEATS_C == ONE_C) ? ST_POST : ST_DATA;
        end else begin
          state_nxt    = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // an underrun still drives a strobed slot, fully masked with zero data
  always_comb begin
    ld_data  = 1'b0;
    dqs_pat  = DQS_IDLE;
    dq_oe_d  = 1'b0;
    dqs_oe_d = 1'b0;
    tx_data  = bus.WR_DATA;
    tx_mask  = bus.WR_MASK;
    case (state)
      ST_IDLE: dqs_oe_d = bus.WR_VALID;
      ST_PRE, ST_DATA: begin
        ld_data  = 1'b1;
        dqs_pat  = DQS_TOGGLE;
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        if (!bus.WR_VALID) begin
          tx_data = '0;
          tx_mask = '1;
        end
      end
      ST_POST: begin
        dqs_oe_d = 1'b1;
        if (bus.WR_VALID) begin
          ld_data = 1'b1;
          dqs_pat = DQS_TOGGLE;
          dq_oe_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ddr_tx_oreg #(.DQ_W(DQ_W), .DM_W(DM_W)) u_oreg (
    .clk_int  (CLK),
    .clr      (!RST_N),
    .ld_data  (ld_data),
    .data     (tx_data),
    .mask     (tx_mask),
    .dqs_pat  (dqs_pat),
    .dq_oe_d  (dq_oe_d),
    .dqs_oe_d (dqs_oe_d),
    .dq_hi    (bus.DQ_HI),
    .dq_lo    (bus.DQ_LO),
    .dm_hi    (bus.DM_HI),
    .dm_lo    (bus.DM_LO),
    .dqs_hi   (bus.DQS_HI),
    .dqs_lo   (bus.DQS_LO),
    .dq_oe    (bus.DQ_OE),
    .dqs_oe   (bus.DQS_OE)
  );

  assign bus.WR_READY     = (state != ST_IDLE);
  assign bus.BUSY         = (state != ST_IDLE);
  assign bus.UNDERRUN_CNT = urun_cnt;

endmodule

// File: tb/tb_ddr_wdata_tx.sv
// Directed bench for ddr_wdata_tx: scoreboarded beats plus burst framing checks.
module tb_ddr_wdata_tx;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // {dq_hi, dq_lo, dm_hi, dm_lo}
  logic [35:0] q4[$];
  logic [35:0] q1[$];
  int run[2]      = '{0, 0};
  int last_run[2] = '{0, 0};
  int amb[2]      = '{0, 0};

  always #5 CLK = ~CLK;

  ddr_wdata_tx_if #(.DQ_W(16)) if4 ();
  ddr_wdata_tx_if #(.DQ_W(16)) if1 ();

  ddr_wdata_tx #(.DQ_W(16), .BEATS(4)) u_dut  (.CLK(CLK), .RST_N(RST_N), .bus(if4.slave));
  ddr_wdata_tx #(.DQ_W(16), .BEATS(1)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(if1.slave));

  logic [39:0] o4, o1;
  assign o4 = {if4.DQ_HI, if4.DQ_LO, if4.DM_HI, if4.DM_LO, if4.DQS_HI, if4.DQS_LO, if4.DQ_OE, if4.DQS_OE};
  assign o1 = {if1.DQ_HI, if1.DQ_LO, if1.DM_HI, if1.DM_LO, if1.DQS_HI, if1.DQS_LO, if1.DQ_OE, if1.DQS_OE};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bw(input int i);
    logic [15:0] a, b;
    a = 16'(i * 'h1111);
    b = 16'((i + 1) * 'h1111);
    return {b, a};
  endfunction

  task automatic mon_step(input int s, input logic [39:0] o);
    logic [35:0] e;
    int sz;
    sz = (s == 0) ? q4.size() : q1.size();
    if (o[1]) begin
      chk("oe_imply", {63'd0, o[0]}, 64'd1);
      chk("dqs_toggle", {62'd0, o[3:2]}, 64'd2);
      if (sz == 0) begin
        chk("sb_underflow", {63'd0, o[1]}, 64'd0);
      end else begin
        if (s == 0) e = q4.pop_front();
        else        e = q1.pop_front();
        chk("sb_beat", {28'd0, o[39:4]}, {28'd0, e});
      end
      run[s]++;
    end else begin
      chk("dqs_quiet", {62'd0, o[3:2]}, 64'd0);
      if (run[s] > 0) begin
        last_run[s] = run[s];
        run[s] = 0;
      end
      if (o[0]) amb[s]++;
    end
  endtask

  task automatic drive(input bit s, input logic v, input logic [31:0] d, input logic [3:0] m);
    if (s) begin
      if1.WR_VALID = v; if1.WR_DATA = d; if1.WR_MASK = m;
    end else begin
      if4.WR_VALID = v; if4.WR_DATA = d; if4.WR_MASK = m;
    end
  endtask

  task automatic send_beat(input bit s, input logic [31:0] d, input logic [3:0] m);
    int   n = 0;
    logic rdy;
    drive(s, 1'b1, d, m);
    @(negedge CLK);
    rdy = s ? if1.WR_READY : if4.WR_READY;
    while (!rdy && n < 20) begin
      @(negedge CLK);
      rdy = s ? if1.WR_READY : if4.WR_READY;
      n++;
    end
    if (!rdy) chk("ready_timeout", {63'd0, rdy}, 64'd1);
    else if (s) q1.push_back({d[15:0], d[31:16], m[1:0], m[3:2]});
    else        q4.push_back({d[15:0], d[31:16], m[1:0], m[3:2]});
    @(posedge CLK); #1;
  endtask

  task automatic gap(input bit s, input int n, input bit under);
    drive(s, 1'b0, 32'd0, 4'd0);
    if (under)
      for (int k = 0; k < n; k++) begin
        if (s) q1.push_back({32'd0, 4'hF});
        else   q4.push_back({32'd0, 4'hF});
      end
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    drive(0, 1'b0, 32'd0, 4'd0);
    drive(1, 1'b0, 32'd0, 4'd0);
    #1;
    chk("t0_dq_oe", {63'd0, if4.DQ_OE}, 64'd0);
    chk("t0_dqs_oe", {63'd0, if4.DQS_OE}, 64'd0);
    fork
      forever begin
        @(negedge CLK);
        mon_step(0, o4);
        mon_step(1, o1);
      end
    join_none
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {63'd0, if4.BUSY}, 64'd0);
    chk("rst_ready", {63'd0, if4.WR_READY}, 64'd0);
    chk("rst_dq_hi", {48'd0, if4.DQ_HI}, 64'd0);
    chk("rst_urun", {56'd0, if4.UNDERRUN_CNT}, 64'd0);
    RST_N = 1'b1;

    // single burst
    amb[0] = 0;
    for (int i = 0; i < 4; i++) send_beat(0, bw(i), 4'(i * 5));
    gap(0, 3, 0);
    chk("b1_run", last_run[0], 4);
    chk("b1_ambles", amb[0], 2);
    chk("b1_dqs_oe_off", {63'd0, if4.DQS_OE}, 64'd0);
    chk("b1_busy_off", {63'd0, if4.BUSY}, 64'd0);

    // two bursts back-to-back
    amb[0] = 0;
    for (int i = 0; i < 8; i++) send_beat(0, bw(i), 4'(i * 3));
    gap(0, 3, 0);
    chk("b2_run", last_run[0], 8);
    chk("b2_ambles", amb[0], 2);

    // two-cycle underrun after beat 2
    amb[0] = 0;
    send_beat(0, bw(0), 4'h1);
    send_beat(0, bw(1), 4'h2);
    gap(0, 2, 1);
    send_beat(0, bw(2), 4'h4);
    send_beat(0, bw(3), 4'h8);
    gap(0, 3, 0);
    chk("ur_cnt", {56'd0, if4.UNDERRUN_CNT}, 64'd2);
    chk("ur_run", last_run[0], 6);
    chk("ur_ambles", amb[0], 2);

    // reset during beat 3
    amb[0] = 0;
    send_beat(0, bw(0), 4'h0);
    send_beat(0, bw(1), 4'h0);
    drive(0, 1'b1, bw(2), 4'h0);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("ra_dq_oe", {63'd0, if4.DQ_OE}, 64'd0);
    chk("ra_dqs_oe", {63'd0, if4.DQS_OE}, 64'd0);
    chk("ra_busy", {63'd0, if4.BUSY}, 64'd0);
    chk("ra_ready", {63'd0, if4.WR_READY}, 64'd0);
    chk("ra_urun", {56'd0, if4.UNDERRUN_CNT}, 64'd0);
    drive(0, 1'b0, 32'd0, 4'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("ra_ambles", amb[0], 1);
    chk("ra_run", last_run[0], 2);
    amb[0] = 0;
    for (int i = 4; i < 8; i++) send_beat(0, bw(i), 4'(i));
    gap(0, 3, 0);
    chk("ra_fresh_run", last_run[0], 4);
    chk("ra_fresh_ambles", amb[0], 2);

    // underrun counter saturation
    send_beat(0, bw(1), 4'h3);
    gap(0, 300, 1);
    for (int i = 2; i < 5; i++) send_beat(0, bw(i), 4'hC);
    gap(0, 3, 0);
    chk("sat_cnt", {56'd0, if4.UNDERRUN_CNT}, 64'd255);
    chk("sat_run", last_run[0], 304);

    // BEATS=1 continuous stream
    amb[1] = 0;
    for (int i = 0; i < 5; i++) send_beat(1, bw(i), 4'(9 - i));
    chk("b1s_busy", {63'd0, if1.BUSY}, 64'd1);
    gap(1, 3, 0);
    chk("b1s_run", last_run[1], 5);
    chk("b1s_ambles", amb[1], 2);
    chk("b1s_busy_off", {63'd0, if1.BUSY}, 64'd0);

    chk("sb_drain4", q4.size(), 0);
    chk("sb_drain1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_wdata_tx.md
DDR_WDATA_TX -- requirements
Module: ddr_wdata_tx

Interface
REQ-001 Parameter DQ_W, default 16: DQ pad width; SHALL be a multiple of 8.
REQ-002 Parameter BEATS, default 4: accepted beats per burst (BL8 = 4 cycles); range 1-255.
REQ-003 Derived DM_W = DQ_W/8.
REQ-004 Ports (name / direction / width / meaning):
- CLK / in / 1 / only clock; all logic is rising-edge.
- RST_N / in / 1 / reset; synchronous, active-low.
- WR_VALID / in / 1 / write beat valid.
- WR_READY / out / 1 / beat accepted when WR_VALID & WR_READY at a CLK edge.
- WR_DATA / in / 2*DQ_W / [DQ_W-1:0] is the rising half; upper bits are the falling half.
- WR_MASK / in / 2*DM_W / byte mask, same split as WR_DATA; 1 = masked.
- DQ_HI, DQ_LO / out / DQ_W / ODDR rising and falling data.
- DM_HI, DM_LO / out / DM_W / ODDR rising and falling mask.
- DQS_HI, DQS_LO / out / 1 / ODDR strobe halves.
- DQ_OE / out / 1 / DQ/DM output enable.
- DQS_OE / out / 1 / DQS output enable.
- BUSY / out / 1 / state != IDLE.
- UNDERRUN_CNT / out / 8 / saturating count of underrun cycles.

Function
REQ-005 FSM states: IDLE, PRE, DATA, POST.
REQ-006 WR_READY SHALL be combinational: 1 in PRE, DATA and POST; 0 in IDLE.
REQ-007 All pad-side outputs SHALL be registered; a beat accepted at edge k appears on DQ/DM from edge k until edge k+1.
REQ-008 IDLE with WR_VALID=1 at an edge:
- Next state PRE.
- DQS_OE<=1, DQS_HI/LO<=0/0, DQ_OE<=0 (preamble).
REQ-009 PRE at an edge: next state DATA; beat counter<=0. A beat is accepted if WR_VALID=1, otherwise the underrun rule (REQ-011) applies.
REQ-010 Accepted beat in PRE or DATA:
- DQ_HI<=WR_DATA low half; DQ_LO<=WR_DATA high half; DM likewise from WR_MASK.
- DQS_HI/LO<=1/0; DQ_OE<=1; beat counter increments.
REQ-011 Underrun (PRE or DATA with WR_VALID=0):
- DQ<=0, DM<=all 1s, DQS_HI/LO<=1/0, DQ_OE<=1.
- Beat counter does not advance; UNDERRUN_CNT increments, saturating at 255.
REQ-012 When the accepted beat count reaches BEATS, next state SHALL be POST.
REQ-013 POST with WR_VALID=1:
- Seamless continuation: beat accepted per REQ-010, counter<=1, next state DATA.
- No postamble is driven.
- If BEATS=1, next state POST instead.
REQ-014 POST with WR_VALID=0:
- Postamble: DQ_OE<=0, DQS_OE<=1, DQS 0/0.
- Next state IDLE.
REQ-015 IDLE with WR_VALID=0: DQS_OE<=0, DQ_OE<=0, DQS 0/0; DQ/DM hold their value.
REQ-016 DQ_OE=1 SHALL imply DQS_OE=1 in every cycle.
REQ-017 The beat counter SHALL be ceil(log2(BEATS+1)) bits wide and never wrap within a burst.

Reset
REQ-018 While RST_N=0 at an edge:
- State<=IDLE; beat counter and UNDERRUN_CNT<=0.
- All DQ/DM/DQS/OE outputs<=0; BUSY=0.
REQ-019 Reset asserted mid-burst SHALL abort the burst: both OEs are 0 from the edge that samples RST_N=0, with no postamble; WR_READY=0 in the following cycle.
REQ-020 Outputs SHALL also initialise to 0 at time zero for simulation.

Structure
REQ-021 Shared package ddr_tx_pkg SHALL hold the state enum, the DQS pattern constants (DQS_TOGGLE=2'b01 as {LO,HI}, DQS_IDLE=2'b00) and the counter-width function.
REQ-022 Sub-module ddr_tx_oreg SHALL hold the registered DQ/DM/DQS/OE output bank with synchronous clear; the FSM and counters SHALL live in the top level.
REQ-023 The block SHALL NOT instantiate ODDR primitives; DQS phase shift is external.

Verification
REQ-024 Single burst, BEATS=4, WR_VALID held high with data 0x1111_0000..0x4444_3333 → preamble 1 cycle, then 4 DATA cycles with DQ_HI=0x0000,0x1111,.. and DQ_LO=0x1111,.., then 1 postamble cycle, then OEs=0.
REQ-025 Two bursts back-to-back with no gap → 8 contiguous DQ_OE=1 cycles, a single preamble and a single postamble.
REQ-026 WR_VALID dropped for 2 cycles after beat 2 → 2 cycles with DM=0x3/0x3 and DQ=0, UNDERRUN_CNT=2, 4 real beats still emitted.
REQ-027 RST_N low during beat 3 → DQ_OE=DQS_OE=0 on the next edge, no postamble, BUSY=0, and a fresh burst afterwards starts with a preamble.
REQ-028 300 underrun cycles → UNDERRUN_CNT saturates at 255.
REQ-029 BEATS=1 with a continuous stream → DQS toggles every cycle and POST persists without a postamble until WR_VALID falls.
